// File: rtl/epbus_pkg.sv
// Shared definitions for the epRISC peripheral bus master.
package epbus_pkg;

   // Master FSM encoding; the numeric values are fixed so debug dumps stay readable.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } epbusState_e;

   localparam int BUS_W        = 32;
   localparam int REGS_PER_DEV = 4;

   // Value returned when a read targets a slot with no peripheral behind it.
   localparam logic [BUS_W-1:0] UNMAPPED_RD = 32'h0000_00EA;

endpackage

// File: rtl/epbus_irq_prio.sv
// Registered lowest-index priority encoder for the peripheral interrupt lines.
module epbus_irq_prio #(
   parameter int NUM_DEV = 4,
   parameter int DEV_W   = 2
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic [NUM_DEV-1:0] iDevInt,
   output logic               oIrq,
   output logic [DEV_W-1:0]   oIrqId
);

   logic             irq_q, irq_d;
   logic [DEV_W-1:0] irqId_q, irqId_d;
   logic [DEV_W-1:0] lowest;

   // Find the lowest asserting line; scanning downward lets the lowest index win.
   always_comb begin
      lowest = '0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if (iDevInt[i]) begin
            lowest = DEV_W'(i);
         end
      end
   end

   // Next state: the ID is kept from the last active source when everything goes quiet.
   always_comb begin
      irq_d   = |iDevInt;
      irqId_d = irqId_q;
      if (|iDevInt) begin
         irqId_d = lowest;
      end
   end

   // Register the interrupt summary every cycle.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         irq_q   <= 1'b0;
         irqId_q <= '0;
      end else begin
         irq_q   <= irq_d;
         irqId_q <= irqId_d;
      end
   end

   assign oIrq   = irq_q;
   assign oIrqId = irqId_q;

endmodule

// File: rtl/epbus_master.sv
// epRISC peripheral bus initiator: single-beat CPU requests to a shared tristate bus.
module epbus_master
   import epbus_pkg::*;
#(
   parameter int NUM_DEV = 4,
   parameter int DEV_W   = 2,
   parameter int WAIT    = 0
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic               iReqValid,
   output logic               oReqReady,
   input  logic               iReqWrite,
   input  logic [DEV_W+1:0]   iReqAddr,
   input  logic [BUS_W-1:0]   iReqData,
   output logic               oRespValid,
   output logic [BUS_W-1:0]   oRespData,
   output logic [1:0]         oBusAddr,
   inout  wire  [BUS_W-1:0]   bBusData,
   output logic               oBusWrite,
   output logic [NUM_DEV-1:0] oBusEnable,
   input  logic [NUM_DEV-1:0] iDevInt,
   output logic               oIrq,
   output logic [DEV_W-1:0]   oIrqId
);

   epbusState_e        state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [BUS_W-1:0]   wdata_q, wdata_d;
   logic [1:0]         busAddr_q, busAddr_d;
   logic               busWrite_q, busWrite_d;
   logic [NUM_DEV-1:0] busEn_q, busEn_d;
   logic               respValid_q, respValid_d;
   logic [BUS_W-1:0]   respData_q, respData_d;
   logic [NUM_DEV-1:0] decEn;

   // One-hot slot decode of the incoming request; an index past NUM_DEV matches nothing.
   always_comb begin
      decEn = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         decEn[i] = (iReqAddr[DEV_W+1:2] == DEV_W'(i));
      end
   end

   // Next-state and registered-output logic for the IDLE -> ACCESS -> RESP sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wdata_d     = wdata_q;
      busAddr_d   = busAddr_q;
      busWrite_d  = busWrite_q;
      busEn_d     = busEn_q;
      respValid_d = 1'b0;
      respData_d  = respData_q;
      case (state_q)
         ST_IDLE: begin
            if (iReqValid) begin
               state_d    = ST_ACCESS;
               cnt_d      = 4'(WAIT);
               wdata_d    = iReqData;
               busAddr_d  = iReqAddr[1:0];
               busWrite_d = iReqWrite;
               busEn_d    = decEn;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d     = ST_RESP;
               respValid_d = 1'b1;
               if (busWrite_q) begin
                  respData_d = '0;
               end else if (|busEn_q) begin
                  respData_d = bBusData;
               end else begin
                  respData_d = UNMAPPED_RD;
               end
               busAddr_d  = '0;
               busWrite_d = 1'b0;
               busEn_d    = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset abandons any access in flight and releases the bus at once.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wdata_q     <= '0;
         busAddr_q   <= '0;
         busWrite_q  <= 1'b0;
         busEn_q     <= '0;
         respValid_q <= 1'b0;
         respData_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         busAddr_q   <= busAddr_d;
         busWrite_q  <= busWrite_d;
         busEn_q     <= busEn_d;
         respValid_q <= respValid_d;
         respData_q  <= respData_d;
      end
   end

   // The write flag is only ever set during ACCESS, so it alone gates the data drivers.
   assign bBusData   = busWrite_q ? wdata_q : 'z;

   assign oReqReady  = (state_q == ST_IDLE);
   assign oRespValid = respValid_q;
   assign oRespData  = respData_q;
   assign oBusAddr   = busAddr_q;
   assign oBusWrite  = busWrite_q;
   assign oBusEnable = busEn_q;

   epbus_irq_prio #(
      .NUM_DEV (NUM_DEV),
      .DEV_W   (DEV_W)
   ) uIrqPrio (
      .iClk    (iClk),
      .iRst    (iRst),
      .iDevInt (iDevInt),
      .oIrq    (oIrq),
      .oIrqId  (oIrqId)
   );

endmodule

// File: doc/epbus_master.md
Name: epbus_master

Overview:
- Initiator side of the epRISC peripheral bus.
- Accepts single-beat read/write requests from the CPU core over a valid/ready handshake.
- Decodes the device index to a one-hot enable, drives address, write strobe and data onto the shared tristate bus, then returns read data or a write completion.
- Also aggregates the per-device interrupt lines into one prioritised CPU interrupt with a source ID.

Parameters:
- NUM_DEV, 4, number of peripheral slots; each slot owns 4 32-bit registers.
- DEV_W, 2, width of the device-index field; requires 2^DEV_W >= NUM_DEV.
- WAIT, 0, extra bus cycles per access (0..15); the access phase lasts WAIT+1 cycles.

Ports:
- iClk  in  1  system clock
- iRst  in  1  synchronous, active-high reset
- iReqValid  in  1  request valid
- oReqReady  out  1  master idle and able to accept
- iReqWrite  in  1  1 = write, 0 = read
- iReqAddr  in  DEV_W+2  {device index, register[1:0]}
- iReqData  in  32  write data
- oRespValid  out  1  one-cycle completion pulse
- oRespData  out  32  read data; 0 after a write
- oBusAddr  out  2  register select to peripherals
- bBusData  inout  32  shared tristate data bus
- oBusWrite  out  1  write strobe
- oBusEnable  out  NUM_DEV  one-hot device enable
- iDevInt  in  NUM_DEV  peripheral interrupt lines
- oIrq  out  1  any interrupt pending
- oIrqId  out  DEV_W  lowest-index asserting device

Behaviour:
- Reset (synchronous, active-high): state IDLE, oReqReady=1, oRespValid=0, oRespData=0, oBusEnable=0, oBusWrite=0, oBusAddr=0, bBusData released (Z), oIrq=0, oIrqId=0, wait counter=0.
- Reset mid-transaction aborts it. No response is issued, and the bus is released from the reset edge onward.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - oReqReady=1.
  - When iReqValid&&oReqReady, register write flag, address and data.
  - Go to ACCESS and load the counter with WAIT.
- ACCESS:
  - oBusAddr = reg field.
  - oBusEnable = one-hot of device index.
  - oBusWrite = write flag.
  - bBusData is driven with the stored data only when ACCESS and write; Z otherwise.
  - The counter decrements each cycle; on the cycle the counter is 0, a read samples bBusData into oRespData, then the FSM goes to RESP.
  - All bus outputs are registered and held stable for all WAIT+1 cycles.
- Out-of-range device index (index >= NUM_DEV):
  - oBusEnable stays 0 for the whole access.
  - The read response is 32'h000000EA.
  - A write is silently dropped but still completes.
- RESP:
  - oRespValid=1 for exactly one cycle; bus outputs are 0.
  - Return to IDLE; oReqReady rises the following cycle. This gives a guaranteed one-cycle bus turnaround between transactions.
- Latency: request accepted at edge N; ACCESS covers cycles N+1..N+1+WAIT; oRespValid is high in cycle N+2+WAIT.
- Throughput: one transaction per WAIT+3 cycles.
- oRespData holds its value until the next read completes. A write completion sets it to 0.
- iReqValid while not ready is ignored. There is no queuing; the requester must hold the request until the handshake.
- Interrupts:
  - Registered every cycle, independent of FSM state.
  - oIrq = |iDevInt[NUM_DEV-1:0].
  - oIrqId = index of the lowest set bit; it holds its previous value when none is set.
  - Simultaneous sources are resolved to the lowest index.
  - Latency is 1 cycle.

Decomposition:
- Shared package epbus_pkg holds:
  - FSM state encoding (IDLE=0, ACCESS=1, RESP=2)
  - bus data width constant (32)
  - registers-per-device constant (4)
  - unmapped read value constant 32'hEA
- Sub-module epbus_irq_prio: a registered lowest-index priority encoder for iDevInt, producing oIrq/oIrqId.
- The FSM and bus drive remain in epbus_master.

Test Plan:
- Write, WAIT=0: addr 0x2 (dev0, reg2), data 0x000000A5 -> cycle N+1: oBusEnable=4'b0001, oBusAddr=2, oBusWrite=1, bBusData=0xA5; cycle N+2: oRespValid=1, oRespData=0, bus Z.
- Read, WAIT=2: addr 0x7 (dev1, reg3), responder model drives 0xDEADBEEF while enabled -> oBusEnable=4'b0010 for exactly 3 cycles with oBusWrite=0 and master bus Z; oRespValid in N+4 with oRespData=0xDEADBEEF.
- Unmapped device, NUM_DEV=3: read at addr 0xC -> oBusEnable stays 0 throughout; oRespData=0x000000EA.
- Back-to-back requests with iReqValid held high -> second handshake exactly WAIT+3 cycles after the first; never two adjacent ACCESS cycles from different requests.
- Reset during ACCESS of a write -> at the reset edge oBusEnable=0, oBusWrite=0, bus Z; no oRespValid pulse; oReqReady=1 after reset.
- Interrupts: iDevInt=4'b1010 -> next cycle oIrq=1, oIrqId=1; change to 4'b1000 -> oIrqId=3; change to 0 -> oIrq=0, oIrqId holds 3.
